// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the 8-bit ALU datapath blocks: the adder_8bit
// primitive and the add/subtract wrapper that drives it.
//   ALU_WIDTH : datapath width in bits
//   word_t    : one datapath word
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef logic [ALU_WIDTH-1:0] word_t;

endpackage : alu_pkg

// File: rtl/adder_8bit_if.sv
// -----------------------------------------------------------------------------
// adder_8bit_if
// Operand/result bundle of the registered adder.
//   in_valid, A, B, cin           : operand side, driven by the master
//   sum, cout, ovf, zero, out_valid : registered result side, driven by the adder
// Modports:
//   master : the client issuing additions (e.g. the add/subtract wrapper)
//   slave  : the adder itself
// -----------------------------------------------------------------------------
interface adder_8bit_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);

    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;

    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             out_valid;

    modport master (
        output in_valid, A, B, cin,
        input  sum, cout, ovf, zero, out_valid
    );

    modport slave (
        input  in_valid, A, B, cin,
        output sum, cout, ovf, zero, out_valid
    );

endinterface : adder_8bit_if

// File: rtl/adder_8bit_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full-adder cell; the ripple chain of adder_8bit is built from these.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic half_s;

    assign half_s = a ^ b;
    assign s      = half_s ^ ci;
    // Generate when both bits set, propagate the incoming carry otherwise.
    assign co     = (a & b) | (ci & half_s);

endmodule : full_adder

// File: rtl/adder_8bit.sv
// -----------------------------------------------------------------------------
// adder_8bit
// Registered ripple-carry adder: {cout, sum} = A + B + cin with signed
// overflow and zero flags, one-cycle latency, one operation per cycle.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, takes priority over in_valid
//   bus : adder_8bit_if.slave
//         in_valid/A/B/cin captured on the rising edge when in_valid = 1;
//         sum/cout/ovf/zero hold between accepted operations;
//         out_valid pulses one cycle after each accepted operation.
// -----------------------------------------------------------------------------
module adder_8bit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    adder_8bit_if.slave  bus
);

    // carry_s[i] is the carry into cell i; carry_s[WIDTH] is the carry out.
    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;
    logic             ovf_s;
    logic             zero_s;

    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;
    logic             out_valid_r;

    assign carry_s[0] = bus.cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_adder u_fa (
                .a  (bus.A[gi]),
                .b  (bus.B[gi]),
                .ci (carry_s[gi]),
                .s  (sum_s[gi]),
                .co (carry_s[gi+1])
            );
        end
    endgenerate

    // Signed overflow: the carry entering the sign bit disagrees with the
    // carry leaving it. Zero looks at the result bits only, not cout.
    assign ovf_s  = carry_s[WIDTH-1] ^ carry_s[WIDTH];
    assign zero_s = (sum_s == {WIDTH{1'b0}});

    // Result/flag register stage: reset clears, accept loads, idle holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r       <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (bus.in_valid) begin
            sum_r       <= sum_s;
            cout_r      <= carry_s[WIDTH];
            ovf_r       <= ovf_s;
            zero_r      <= zero_s;
            out_valid_r <= 1'b1;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;
    assign bus.out_valid = out_valid_r;

endmodule : adder_8bit

// File: tb/tb_adder_8bit.sv
// -----------------------------------------------------------------------------
// tb_adder_8bit
// Scoreboard bench for adder_8bit. Each clock edge the stimulus process
// updates an arithmetic reference model and pushes the expected registered
// state; a monitor pops one entry per falling edge and compares every output.
// -----------------------------------------------------------------------------
module tb_adder_8bit;
    import alu_pkg::*;

    typedef struct {
        word_t sum;
        logic  cout;
        logic  ovf;
        logic  zero;
        logic  out_valid;
    } exp_t;

    logic clk;
    logic rst;

    adder_8bit_if #(.WIDTH(ALU_WIDTH)) bus_if ();

    adder_8bit #(.WIDTH(ALU_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state (value of the DUT registers after the last edge).
    word_t m_sum;
    logic  m_cout;
    logic  m_ovf;
    logic  m_zero;
    logic  m_ov;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    // Applies one cycle of inputs, then advances the model on the edge.
    task automatic cycle(input logic r, input logic v, input word_t a,
                         input word_t b, input logic c);
        int unsigned total;
        int          sa;
        int          sb;
        int          ssum;
        exp_t        e;
        rst         = r;
        bus_if.in_valid = v;
        bus_if.A    = a;
        bus_if.B    = b;
        bus_if.cin  = c;
        @(posedge clk);
        if (r) begin
            m_sum = 8'h00; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0; m_ov = 1'b0;
        end else if (v) begin
            total  = int'(a) + int'(b) + (c ? 1 : 0);
            m_sum  = word_t'(total % 256);
            m_cout = (total > 255);
            sa     = $signed(a);
            sb     = $signed(b);
            ssum   = sa + sb + (c ? 1 : 0);
            m_ovf  = (ssum > 127) || (ssum < -128);
            m_zero = (total % 256) == 0;
            m_ov   = 1'b1;
        end else begin
            m_ov = 1'b0;
        end
        e.sum = m_sum; e.cout = m_cout; e.ovf = m_ovf; e.zero = m_zero; e.out_valid = m_ov;
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: one expected record per cycle, compared on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_valid", int'(bus_if.out_valid), int'(e.out_valid));
            check("sum",       int'(bus_if.sum),       int'(e.sum));
            check("cout",      int'(bus_if.cout),      int'(e.cout));
            check("ovf",       int'(bus_if.ovf),       int'(e.ovf));
            check("zero",      int'(bus_if.zero),      int'(e.zero));
        end
    end

    initial begin
        int drain;
        rst = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.A = 8'h00;
        bus_if.B = 8'h00;
        bus_if.cin = 1'b0;
        m_sum = 8'h00; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0; m_ov = 1'b0;

        // Reset wins over a valid all-ones operation.
        cycle(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
        cycle(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);

        // Basic add, with and without carry-in.
        cycle(1'b0, 1'b1, 8'h0F, 8'h01, 1'b0);
        cycle(1'b0, 1'b1, 8'h0F, 8'h01, 1'b1);
        // Carry wrap.
        cycle(1'b0, 1'b1, 8'hFF, 8'h01, 1'b0);
        cycle(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
        // Subtraction through inverted B and cin = 1.
        cycle(1'b0, 1'b1, 8'h05, 8'hFC, 1'b1);
        cycle(1'b0, 1'b1, 8'h03, 8'hFA, 1'b1);
        // Signed overflow in both directions.
        cycle(1'b0, 1'b1, 8'h7F, 8'h01, 1'b0);
        cycle(1'b0, 1'b1, 8'h80, 8'hFF, 1'b0);
        // Idle with fresh operands: outputs hold, out_valid drops.
        cycle(1'b0, 1'b0, 8'h12, 8'h34, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        // Three back-to-back operations, reset arriving with the third.
        cycle(1'b0, 1'b1, 8'h21, 8'h43, 1'b0);
        cycle(1'b0, 1'b1, 8'hA0, 8'h60, 1'b0);
        cycle(1'b1, 1'b1, 8'h7F, 8'h7F, 1'b1);
        // Three clean back-to-back operations.
        cycle(1'b0, 1'b1, 8'h10, 8'h20, 1'b1);
        cycle(1'b0, 1'b1, 8'hC8, 8'h38, 1'b0);
        cycle(1'b0, 1'b1, 8'h55, 8'hAA, 1'b1);

        // Randomized traffic with occasional idles and resets.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 3) != 0),
                  word_t'($urandom_range(0, 255)),
                  word_t'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        end
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Let the monitor drain the scoreboard, bounded.
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_adder_8bit

// File: doc/adder_8bit.md
Name: adder_8bit

Overview:
- Registered 8-bit ripple-carry adder with carry-in: sum = A + B + cin, with carry-out and status flags.
- Datapath primitive of the 8-bit ALU; the add/subtract wrapper drives cin = mode and supplies B or its one's complement (cin = 1, B inverted gives A - B).
- One clock, one-cycle latency, valid-qualified input.

Parameters:
- WIDTH, 8, operand/result width in bits; all values below assume 8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid this cycle; capture on rising edge
- A  input  WIDTH  operand A, unsigned or two's complement
- B  input  WIDTH  operand B, unsigned or two's complement
- cin  input  1  carry-in (LSB)
- sum  output  WIDTH  registered result bits [WIDTH-1:0]
- cout  output  1  registered carry out of MSB
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB
- zero  output  1  registered, 1 when sum == 0
- out_valid  output  1  registered; high one cycle after an accepted in_valid

Behaviour:
- Reset: on a rising edge with rst = 1, sum = 0, cout = 0, ovf = 0, zero = 0, out_valid = 0. rst has priority over in_valid.
- Accept: on a rising edge with rst = 0 and in_valid = 1:
  - {cout, sum} <= A + B + cin, computed at full WIDTH+1 width, no truncation of carry.
  - ovf <= (A[MSB] == B[MSB]) && (result[MSB] != A[MSB]).
  - zero <= (result[WIDTH-1:0] == 0), independent of cout.
  - out_valid <= 1.
- Idle: on a rising edge with rst = 0 and in_valid = 0:
  - sum, cout, ovf and zero hold their previous values.
  - out_valid <= 0.
- Latency: exactly 1 cycle from accepted input to output. Throughput: 1 operation per cycle; back-to-back in_valid is allowed.
- Combinational core: WIDTH chained full-adder cells; bit 0 carry-in = cin, cell i carry-out feeds cell i+1. No lookahead required.
- Wrap-around: results wrap mod 2^WIDTH, and the overflowed bit appears on cout only.
- Reset asserted mid-stream: the pending operation is discarded, and out_valid is 0 on the next cycle.
- No X propagation from unused state; all flops are reset.

Decomposition:
- Shared package alu_pkg holds:
  - constant ALU_WIDTH = 8.
  - typedef word_t = logic [ALU_WIDTH-1:0], used by adder_8bit and the add/subtract wrapper.
- Sub-module full_adder (a, b, ci -> s, co) instantiated WIDTH times via generate loop. The top level adds the output register stage and flag logic.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with in_valid = 1, A = 8'hFF, B = 8'hFF -> sum = 00, cout = 0, ovf = 0, zero = 0, out_valid = 0.
- Basic add: A = 0F, B = 01, cin = 0, in_valid = 1 -> next cycle sum = 10, cout = 0, ovf = 0, zero = 0, out_valid = 1. Same operands with cin = 1 -> sum = 11.
- Carry wrap: A = FF, B = 01, cin = 0 -> sum = 00, cout = 1, zero = 1, ovf = 0. Also A = FF, B = FF, cin = 1 -> sum = FF, cout = 1.
- Subtract usage: A = 05, B = FC (~03), cin = 1 -> sum = 02, cout = 1 (no borrow). A = 03, B = FA (~05), cin = 1 -> sum = FE, cout = 0.
- Signed overflow: A = 7F, B = 01 -> sum = 80, ovf = 1, cout = 0. A = 80, B = FF, cin = 0 -> sum = 7F, ovf = 1, cout = 1.
- Hold/stream/reset: after a result, drop in_valid with new operands -> outputs unchanged, out_valid = 0. Then 3 back-to-back valid ops -> 3 consecutive correct results. Assert rst during the third op -> all outputs 0 the next cycle.
